// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer: FSM state encoding, default
// geometry and a counter-width helper.
package frame_sequencer_pkg;

  localparam int DEF_IMG_WIDTH  = 512;
  localparam int DEF_IMG_HEIGHT = 512;
  localparam int DEF_LB_DEPTH   = 4;
  localparam int DEF_KERNEL     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_sequencer_line_counter.sv
// Column/line position counter for one pixel stream; the column wraps at
// WIDTH-1 and each wrap advances the line count.
module line_counter #(
  parameter int WIDTH  = 512,
  parameter int COL_W  = 9,
  parameter int LINE_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [COL_W-1:0]  col,
  output logic [LINE_W-1:0] line,
  output logic              col_last
);

  assign col_last = (col == COL_W'(WIDTH - 1));

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col  <= '0;
      line <= '0;
    end else if (en) begin
      if (col_last) begin
        col  <= '0;
        line <= line + LINE_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Frame-level controller: ingress/egress position tracking, line-buffer
// credit gating of DMA ingress, line-freed interrupt and frame completion.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int LB_DEPTH   = DEF_LB_DEPTH,
  parameter int KERNEL     = DEF_KERNEL
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_in_valid,
  input  logic        i_in_ready,
  output logic        o_in_enable,
  input  logic        i_out_valid,
  input  logic        i_out_ready,
  output logic        o_out_last,
  output logic        o_interrupt,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [15:0] o_lines_in,
  output logic [15:0] o_lines_out
);

  localparam int OUT_LINES = IMG_HEIGHT - KERNEL + 1;
  localparam int COL_W     = cnt_width(IMG_WIDTH);
  localparam int LINE_W    = cnt_width(IMG_HEIGHT + 1);
  localparam int CRED_W    = cnt_width(LB_DEPTH + 1);

  state_t              state, state_nxt;
  logic [CRED_W-1:0]   credits;
  logic                irq_q, err_q;

  logic [COL_W-1:0]    in_col, out_col;
  logic [LINE_W-1:0]   in_line, out_line;
  logic                in_col_last, out_col_last;
  logic [LINE_W:0]     lines_started;
  logic                more_lines, active;
  logic                frame_clr, in_fire, out_fire, consume, ret;
  logic                in_frame_end, out_frame_end, out_complete;
  logic                bad_in_beat, bad_out_beat, credit_overflow;

  assign frame_clr  = (state == ST_IDLE) && i_start;
  assign active     = (state == ST_RUN) || (state == ST_DRAIN);

  // A line counts as started once its first pixel has arrived.
  assign lines_started = {1'b0, in_line} + {{LINE_W{1'b0}}, (in_col != '0)};
  assign more_lines    = lines_started < (LINE_W + 1)'(IMG_HEIGHT);

  assign o_in_enable = (state == ST_RUN) &&
                       ((in_col != '0) || ((credits != '0) && more_lines));

  assign in_fire      = i_in_valid && i_in_ready && o_in_enable;
  assign out_complete = (out_line == LINE_W'(OUT_LINES));
  assign out_fire     = i_out_valid && i_out_ready && active && !out_complete;

  assign consume       = in_fire && (in_col == '0);
  assign ret           = out_fire && out_col_last;
  assign in_frame_end  = in_fire && in_col_last && (in_line == LINE_W'(IMG_HEIGHT - 1));
  assign o_out_last    = active && out_col_last && (out_line == LINE_W'(OUT_LINES - 1));
  assign out_frame_end = out_fire && o_out_last;

  assign bad_in_beat     = i_in_valid && i_in_ready && !o_in_enable;
  assign bad_out_beat    = i_out_valid && i_out_ready && (state == ST_IDLE);
  assign credit_overflow = ret && !consume && (credits == CRED_W'(LB_DEPTH));

  line_counter #(.WIDTH(IMG_WIDTH), .COL_W(COL_W), .LINE_W(LINE_W)) u_in_cnt (
    .clk      (i_clk),
    .rst      (i_rst),
    .clr      (frame_clr),
    .en       (in_fire),
    .col      (in_col),
    .line     (in_line),
    .col_last (in_col_last)
  );

  line_counter #(.WIDTH(IMG_WIDTH), .COL_W(COL_W), .LINE_W(LINE_W)) u_out_cnt (
    .clk      (i_clk),
    .rst      (i_rst),
    .clr      (frame_clr),
    .en       (out_fire),
    .col      (out_col),
    .line     (out_line),
    .col_last (out_col_last)
  );

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_RUN;
      ST_RUN:   if (in_frame_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_frame_end || out_complete) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      credits <= CRED_W'(LB_DEPTH);
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      irq_q <= ret && more_lines;

      // A simultaneous consume and return leaves the credit count as is.
      if (frame_clr)
        credits <= CRED_W'(LB_DEPTH);
      else if (consume && !ret)
        credits <= credits - CRED_W'(1);
      else if (ret && !consume && (credits != CRED_W'(LB_DEPTH)))
        credits <= credits + CRED_W'(1);

      if (frame_clr)
        err_q <= 1'b0;
      if (bad_in_beat || bad_out_beat || credit_overflow)
        err_q <= 1'b1;
    end
  end

  assign o_interrupt = irq_q;
  assign o_err       = err_q;
  assign o_busy      = (state != ST_IDLE);
  assign o_done      = (state == ST_DONE);
  assign o_lines_in  = 16'(in_line);
  assign o_lines_out = 16'(out_line);

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer on a 4x5 frame: per-cycle pixel-count
// reference model, a vector table, directed corner sequences and random traffic.
module tb_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 5;
  localparam int LB = 4;
  localparam int K  = 3;
  localparam int OL = H - K + 1;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        i_in_ready = 1'b0;
  logic        i_out_valid = 1'b0;
  logic        i_out_ready = 1'b0;
  logic        o_in_enable, o_out_last, o_interrupt, o_busy, o_done, o_err;
  logic [15:0] o_lines_in, o_lines_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .LB_DEPTH(LB), .KERNEL(K)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_in_valid  (i_in_valid),
    .i_in_ready  (i_in_ready),
    .o_in_enable (o_in_enable),
    .i_out_valid (i_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_last  (o_out_last),
    .o_interrupt (o_interrupt),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_lines_in  (o_lines_in),
    .o_lines_out (o_lines_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: frame progress kept as total pixel counts
  // (phase 0 idle, 1 run, 2 drain, 3 done).
  int m_phase, m_in, m_out, m_cred;
  bit m_err, m_irq, live = 1'b0;

  function automatic int m_started();
    return (m_in + W - 1) / W;
  endfunction

  function automatic bit m_en();
    return (m_phase == 1) && (((m_in % W) != 0) || (m_cred > 0 && m_started() < H));
  endfunction

  function automatic bit m_last();
    return (m_phase == 1 || m_phase == 2) && (m_out == OL * W - 1);
  endfunction

  function automatic bit egress_avail();
    return (m_phase == 1 || m_phase == 2) && (m_in / W >= K - 1) &&
           (m_out < W * (m_in / W - (K - 1)));
  endfunction

  task automatic model_step(input bit rst, st, iv, ir, ov, ordy);
    bit en, acc_in, acc_out, cons, ret, nerr;
    int ls;
    if (rst) begin
      m_phase = 0; m_in = 0; m_out = 0; m_cred = LB; m_err = 0; m_irq = 0; live = 1;
      return;
    end
    en = m_en(); ls = m_started(); nerr = m_err; ret = 0; cons = 0;
    if (m_phase == 0 && st) nerr = 0;
    if (iv && ir && !en) nerr = 1;
    if (m_phase == 0 && ov && ordy) nerr = 1;
    if (m_phase == 1 || m_phase == 2) begin
      acc_in  = iv && ir && en;
      acc_out = ov && ordy && (m_out < OL * W);
      cons    = acc_in && (m_in % W == 0);
      ret     = acc_out && ((m_out + 1) % W == 0);
      if (ret && !cons && m_cred == LB) nerr = 1;
      m_cred = m_cred - int'(cons) + int'(ret);
      if (m_cred > LB) m_cred = LB;
      m_in  += int'(acc_in);
      m_out += int'(acc_out);
    end
    m_irq = ret && (ls < H);
    m_err = nerr;
    case (m_phase)
      0: if (st) begin m_phase = 1; m_in = 0; m_out = 0; m_cred = LB; end
      1: if (m_in == H * W) m_phase = 2;
      2: if (m_out == OL * W) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  // One clock: drive at posedge+1, compare against the model at the negedge,
  // advance the model on the posedge, return at posedge+1.
  task automatic cycle(input bit rst, st, iv, ir, ov, ordy);
    i_rst = rst; i_start = st; i_in_valid = iv; i_in_ready = ir;
    i_out_valid = ov; i_out_ready = ordy;
    #4;
    if (live) begin
      check("m_in_enable", o_in_enable, m_en());
      check("m_out_last", o_out_last, m_last());
      check("m_interrupt", o_interrupt, m_irq);
      check("m_busy", o_busy, m_phase != 0);
      check("m_done", o_done, m_phase == 3);
      check("m_err", o_err, m_err);
      check("m_lines_in", o_lines_in, m_in / W);
      check("m_lines_out", o_lines_out, m_out / W);
    end
    @(posedge i_clk);
    model_step(rst, st, iv, ir, ov, ordy);
    #1;
  endtask

  task automatic in_beats(input int n);
    repeat (n) cycle(0, 0, 1, 1, 0, 0);
  endtask

  task automatic out_beats(input int n);
    repeat (n) cycle(0, 0, 0, 0, 1, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit rst, st, iv, ir, ov, ordy;
    bit en, busy, err, done;
    int lin, lout;
  } vec_t;

  vec_t vecs[15];
  int   t_beats, t_last_cnt, t_last_at, t_irq_cnt, t_cyc;
  bit   t_fin, t_done_ok, t_ov;

  initial begin
    // Reset with random inputs.
    repeat (2) cycle(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check("rst_in_enable", o_in_enable, 0);
    check("rst_out_last", o_out_last, 0);
    check("rst_interrupt", o_interrupt, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_lines_in", o_lines_in, 0);
    check("rst_lines_out", o_lines_out, 0);

    // Vector table: mid-frame reset, ignored start, error set and clear.
    //           rst st iv ir ov or  en busy err done lin lout
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0};
    vecs[5]  = '{0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 1, 0};
    vecs[6]  = '{0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 1, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0};
    vecs[8]  = '{0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 1, 0};
    vecs[9]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 1, 1, 0, 0,  0, 0, 1, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 1, 1,  0, 0, 1, 0, 0, 0};
    vecs[13] = '{0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].rst, vecs[i].st, vecs[i].iv, vecs[i].ir, vecs[i].ov, vecs[i].ordy);
      check($sformatf("vec%0d_en", i), o_in_enable, vecs[i].en);
      check($sformatf("vec%0d_busy", i), o_busy, vecs[i].busy);
      check($sformatf("vec%0d_err", i), o_err, vecs[i].err);
      check($sformatf("vec%0d_done", i), o_done, vecs[i].done);
      check($sformatf("vec%0d_lines_in", i), o_lines_in, vecs[i].lin);
      check($sformatf("vec%0d_lines_out", i), o_lines_out, vecs[i].lout);
    end

    // Full frame, egress streamed as soon as output lines become available.
    cycle(0, 1, 0, 0, 0, 0);
    t_beats = 0; t_last_cnt = 0; t_last_at = 0; t_irq_cnt = 0; t_cyc = 0;
    t_fin = 0; t_done_ok = 0;
    while (!t_fin && t_cyc < 100) begin
      t_ov = egress_avail();
      if (t_ov) begin
        t_beats++;
        if (o_out_last) begin t_last_cnt++; t_last_at = t_beats; end
      end
      cycle(0, 0, 1, m_en(), t_ov, 1);
      t_cyc++;
      if (o_interrupt) t_irq_cnt++;
      if (t_ov && t_beats == OL * W) t_done_ok = o_done;
      if (o_done) t_fin = 1;
    end
    check("t2_finished", t_fin, 1);
    check("t2_lines_in", o_lines_in, H);
    check("t2_lines_out", o_lines_out, OL);
    check("t2_irq_count", t_irq_cnt, 1);
    check("t2_last_count", t_last_cnt, 1);
    check("t2_last_beat", t_last_at, OL * W);
    check("t2_done_after_last", t_done_ok, 1);
    check("t2_err", o_err, 0);
    idle(1);
    check("t2_idle", o_busy, 0);

    // Credit exhaustion, mid-line hold without credit, release by egress.
    cycle(0, 1, 0, 0, 0, 0);
    in_beats(13);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      check("t4_en_hold_midline", o_in_enable, 1);
    end
    in_beats(3);
    check("t3_en_blocked", o_in_enable, 0);
    check("t3_lines_in4", o_lines_in, 4);
    cycle(0, 0, 1, 0, 0, 0);
    check("t3_en_still_blocked", o_in_enable, 0);
    out_beats(3);
    check("t3_no_irq_midline", o_interrupt, 0);
    out_beats(1);
    check("t3_irq", o_interrupt, 1);
    check("t3_en_back", o_in_enable, 1);
    check("t3_lines_out1", o_lines_out, 1);
    in_beats(1);
    check("t3_irq_one_cycle", o_interrupt, 0);
    in_beats(3);
    check("t3_lines_in5", o_lines_in, 5);
    out_beats(8);
    check("t3_done", o_done, 1);
    check("t3_lines_out3", o_lines_out, 3);
    check("t3_err", o_err, 0);
    idle(1);
    check("t3_idle", o_busy, 0);

    // Egress line end coincides with an ingress line start.
    cycle(0, 1, 0, 0, 0, 0);
    in_beats(12);
    out_beats(3);
    cycle(0, 0, 1, 1, 1, 1);
    check("t5_irq", o_interrupt, 1);
    check("t5_lines_out1", o_lines_out, 1);
    in_beats(3);
    check("t5_credit_kept", o_in_enable, 1);
    check("t5_err", o_err, 0);
    in_beats(4);
    out_beats(8);
    check("t5_done", o_done, 1);
    idle(1);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      bit r, s, iv, ir, ov, ordy;
      r    = ($urandom_range(0, 299) == 0);
      s    = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ir   = ($urandom_range(0, 15) == 0) ? 1'b1 : m_en();
      ov   = egress_avail() ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 31) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(r, s, iv, ir, ov, ordy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
